// File: rtl/tmr_vote_ctrl.sv
// Sequencing controller for a triple-modular-redundant channel set: collects one
// word per channel, votes 2-of-3, tracks per-channel errors and retires bad channels.
module tmr_vote_ctrl #(
  parameter int W      = 8,
  parameter int TMO    = 15,
  parameter int ERR_TH = 3,
  parameter int CW     = 4
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic [W-1:0] A_D,
  input  logic [W-1:0] B_D,
  input  logic [W-1:0] C_D,
  input  logic         A_V,
  input  logic         B_V,
  input  logic         C_V,
  output logic         ACK,
  output logic [W-1:0] Q,
  output logic         Q_V,
  input  logic         Q_R,
  output logic [2:0]   MIS,
  output logic         UNC,
  output logic [2:0]   FAIL,
  input  logic         CLR_F
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VOTE    = 2'd2;
  localparam logic [1:0] S_OUT     = 2'd3;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0]    r_state;
  logic [7:0]    r_timer;
  logic [2:0]    r_have;
  logic [W-1:0]  r_snap [3];
  logic [CW-1:0] r_cnt  [3];
  logic [2:0]    r_fail;
  logic [W-1:0]  r_q;
  logic [2:0]    r_mis;
  logic          r_unc;
  logic          r_qv;

  logic [W-1:0]  w_din [3];
  logic [2:0]    w_act;
  logic [2:0]    w_new;
  logic [2:0]    w_have_nx;
  logic [1:0]    w_nact;
  logic          w_all_in;
  logic          w_collecting;
  logic [2:0]    w_pres;
  logic [W-1:0]  w_maj;
  logic [W-1:0]  w_x;
  logic [W-1:0]  w_y;
  logic [W-1:0]  w_q;
  logic [2:0]    w_mis;
  logic          w_unc;
  logic [CW-1:0] w_cnt_inc [3];

  assign w_din[0] = A_D;
  assign w_din[1] = B_D;
  assign w_din[2] = C_D;

  assign w_act        = ~r_fail;
  assign w_collecting = (r_state == S_IDLE) || (r_state == S_COLLECT);
  assign w_new        = {C_V, B_V, A_V} & w_act & ~r_have & {3{w_collecting}};
  assign w_have_nx    = r_have | w_new;
  assign w_nact       = {1'b0, w_act[0]} + {1'b0, w_act[1]} + {1'b0, w_act[2]};
  assign w_all_in     = ((w_have_nx & w_act) == w_act);

  assign w_pres = r_have & w_act;
  assign w_maj  = (r_snap[0] & r_snap[1]) | (r_snap[0] & r_snap[2]) | (r_snap[1] & r_snap[2]);
  // With exactly two present, w_x is the lower-indexed one and w_y the other.
  assign w_x    = w_pres[0] ? r_snap[0] : r_snap[1];
  assign w_y    = w_pres[2] ? r_snap[2] : r_snap[1];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_q   = '0;
    w_mis = w_act & ~w_pres;
    w_unc = 1'b1;
    case (w_pres)
      3'b111: begin
        w_q   = w_maj;
        w_mis = {r_snap[2] != w_maj, r_snap[1] != w_maj, r_snap[0] != w_maj};
        w_unc = 1'b0;
      end
      3'b011, 3'b101, 3'b110: begin
        w_q = w_x;
        if (w_x == w_y) begin
          w_unc = 1'b0;
        end else begin
          w_mis = w_act;
        end
      end
      3'b001:  w_q = r_snap[0];
      3'b010:  w_q = r_snap[1];
      3'b100:  w_q = r_snap[2];
      default: w_q = '0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_cnt_inc[i] = (r_cnt[i] == CNT_MAX) ? r_cnt[i] : r_cnt[i] + 1'b1;
    end
  end

  // NOTE: snapshot data is not reset; r_have qualifies it, so stale contents are never used.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (w_new[i]) r_snap[i] <= w_din[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_have  <= '0;
      r_q     <= '0;
      r_mis   <= '0;
      r_unc   <= 1'b0;
      r_qv    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          r_have  <= w_have_nx;
          if (w_new != 3'b000) begin
            r_state <= (w_nact < 2'd2 || w_all_in) ? S_VOTE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_have  <= w_have_nx;
          r_timer <= r_timer + 8'd1;
          if (w_all_in || r_timer == 8'(TMO - 1)) r_state <= S_VOTE;
        end
        S_VOTE: begin
          r_q     <= w_q;
          r_mis   <= w_mis;
          r_unc   <= w_unc;
          r_qv    <= 1'b1;
          r_state <= S_OUT;
        end
        default: begin
          if (r_qv && Q_R) begin
            r_qv    <= 1'b0;
            r_have  <= '0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Error bookkeeping; a clear request overrides any update from a coincident vote.
  always_ff @(posedge CLK) begin
    if (!RN || CLR_F) begin
      r_fail <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else if (r_state == S_VOTE) begin
      for (int i = 0; i < 3; i++) begin
        if (w_mis[i] && w_act[i]) begin
          r_cnt[i] <= w_cnt_inc[i];
          if (w_cnt_inc[i] >= CW'(ERR_TH)) r_fail[i] <= 1'b1;
        end
      end
    end
  end

  assign ACK  = (r_state == S_VOTE);
  assign Q    = r_q;
  assign Q_V  = r_qv;
  assign MIS  = r_mis;
  assign UNC  = r_unc;
  assign FAIL = r_fail;

endmodule

// File: tb/tb_tmr_vote_ctrl.sv
// Self-checking bench for tmr_vote_ctrl: directed scenarios plus randomized votes
// compared against a channel-level reference model of voting and retirement.
module tb_tmr_vote_ctrl;

  localparam int TMO    = 15;
  localparam int ERR_TH = 3;
  localparam int CMAX   = 15;

  logic       clk = 1'b0;
  logic       rn;
  logic [7:0] a_d, b_d, c_d;
  logic       a_v, b_v, c_v;
  logic       ack;
  logic [7:0] q;
  logic       q_v;
  logic       q_r;
  logic [2:0] mis;
  logic       unc;
  logic [2:0] fail_o;
  logic       clr_f;

  int vectors = 0;
  int miscompares = 0;

  int         m_cnt [3];
  logic [2:0] m_fail;
  logic [7:0] e_q;
  logic [2:0] e_mis;
  logic       e_unc;

  tmr_vote_ctrl #(.W(8), .TMO(TMO), .ERR_TH(ERR_TH), .CW(4)) dut (
    .CLK(clk), .RN(rn),
    .A_D(a_d), .B_D(b_d), .C_D(c_d),
    .A_V(a_v), .B_V(b_v), .C_V(c_v),
    .ACK(ack), .Q(q), .Q_V(q_v), .Q_R(q_r),
    .MIS(mis), .UNC(unc), .FAIL(fail_o), .CLR_F(clr_f)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_fail = 3'b000;
  endfunction

  // Vote computed from the list of present channel values.
  function automatic void model_vote(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c);
    logic [7:0] d [3];
    int         p [$];
    logic [2:0] act, pres;
    d[0] = a; d[1] = b; d[2] = c;
    act  = ~m_fail;
    pres = v & act;
    e_q = 8'h00; e_mis = 3'b000; e_unc = 1'b0;
    for (int i = 0; i < 3; i++) if (pres[i]) p.push_back(i);
    if (p.size() == 3) begin
      for (int bt = 0; bt < 8; bt++) begin
        int ones;
        ones = int'(d[0][bt]) + int'(d[1][bt]) + int'(d[2][bt]);
        e_q[bt] = (ones >= 2);
      end
      for (int i = 0; i < 3; i++) e_mis[i] = (d[i] != e_q);
    end else if (p.size() == 2) begin
      e_q = d[p[0]];
      if (d[p[0]] == d[p[1]]) begin
        e_mis = act & ~pres;
      end else begin
        e_mis = act;
        e_unc = 1'b1;
      end
    end else begin
      if (p.size() == 1) e_q = d[p[0]];
      e_mis = act & ~pres;
      e_unc = 1'b1;
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < 3; i++) begin
      if (e_mis[i]) begin
        m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        if (m_cnt[i] >= ERR_TH) m_fail[i] = 1'b1;
      end
    end
  endfunction

  task automatic start_set(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
    a_d = a; b_d = b; c_d = c;
    {c_v, b_v, a_v} = v;
  endtask

  // Waits for ACK with the latency the model predicts, then checks the result.
  task automatic await_vote(input string name);
    logic [2:0] act, pres;
    int         exp_lat, lat;
    act     = ~m_fail;
    pres    = {c_v, b_v, a_v} & act;
    exp_lat = ($countones(act) < 2 || pres == act) ? 1 : TMO + 1;
    model_vote({c_v, b_v, a_v}, a_d, b_d, c_d);
    lat = 0;
    while (lat < TMO + 5) begin
      tick();
      lat++;
      if (ack === 1'b1) break;
    end
    vectors++;
    if (ack !== 1'b1 || lat != exp_lat) begin
      $display("FAIL %s_ack_latency: ack=%b after %0d cycles, want ack=1 after %0d", name, ack, lat, exp_lat);
      miscompares++;
    end
    {c_v, b_v, a_v} = 3'b000;
    tick();
    model_commit();
    vectors++;
    if (ack !== 1'b0 || q_v !== 1'b1 || q !== e_q || mis !== e_mis || unc !== e_unc || fail_o !== m_fail) begin
      $display("FAIL %s_result: ack=%b qv=%b q=%h mis=%b unc=%b fail=%b, want ack=0 qv=1 q=%h mis=%b unc=%b fail=%b",
               name, ack, q_v, q, mis, unc, fail_o, e_q, e_mis, e_unc, m_fail);
      miscompares++;
    end
  endtask

  task automatic release_out(input string name, input int hold);
    q_r = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if (q_v !== 1'b1 || ack !== 1'b0 || q !== e_q || mis !== e_mis || unc !== e_unc) begin
        $display("FAIL %s_hold%0d: qv=%b ack=%b q=%h mis=%b unc=%b, want qv=1 ack=0 q=%h mis=%b unc=%b",
                 name, i, q_v, ack, q, mis, unc, e_q, e_mis, e_unc);
        miscompares++;
      end
    end
    q_r = 1'b1;
    tick();
    q_r = 1'b0;
    vectors++;
    if (q_v !== 1'b0 || ack !== 1'b0) begin
      $display("FAIL %s_release: qv=%b ack=%b, want qv=0 ack=0", name, q_v, ack);
      miscompares++;
    end
  endtask

  task automatic pulse_clear();
    clr_f = 1'b1;
    tick();
    clr_f = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rn = 1'b0;
    tick();
    tick();
    rn = 1'b1;
    model_reset();
    vectors++;
    if (q !== 8'h00 || q_v !== 1'b0 || mis !== 3'b000 || unc !== 1'b0 || ack !== 1'b0 || fail_o !== 3'b000) begin
      $display("FAIL reset_state: q=%h qv=%b mis=%b unc=%b ack=%b fail=%b, want all zero",
               q, q_v, mis, unc, ack, fail_o);
      miscompares++;
    end
  endtask

  task automatic test_clean_vote();
    start_set(3'b111, 8'h5A, 8'h5A, 8'h5A);
    await_vote("clean");
    release_out("clean", 0);
  endtask

  task automatic test_upset_and_retire();
    for (int k = 0; k < 3; k++) begin
      start_set(3'b111, 8'h5A, 8'h5A, 8'h5B);
      await_vote($sformatf("upset%0d", k));
      release_out("upset", 0);
    end
    start_set(3'b011, 8'h11, 8'h11, 8'h00);
    await_vote("retired_nowait");
    release_out("retired_nowait", 1);
  endtask

  task automatic test_degraded();
    for (int k = 0; k < 3; k++) begin
      start_set(3'b011, 8'h0F, 8'hF0, 8'h00);
      await_vote($sformatf("degraded%0d", k));
      release_out("degraded", 0);
    end
    pulse_clear();
    vectors++;
    if (fail_o !== 3'b000) begin
      $display("FAIL clear_pulse: fail=%b, want 000", fail_o);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    start_set(3'b011, 8'h33, 8'h33, 8'hEE);
    await_vote("timeout");
    release_out("timeout", 0);
  endtask

  task automatic test_backpressure();
    start_set(3'b111, 8'h12, 8'h34, 8'h12);
    await_vote("bp_first");
    start_set(3'b111, 8'h77, 8'h77, 8'h77);
    release_out("bp", 10);
    await_vote("bp_pending");
    release_out("bp_pending", 0);
  endtask

  task automatic test_clear_at_vote();
    pulse_clear();
    for (int k = 0; k < 2; k++) begin
      start_set(3'b111, 8'h5A, 8'h5A, 8'h5B);
      await_vote("pre_clear");
      release_out("pre_clear", 0);
    end
    start_set(3'b111, 8'h5A, 8'h5A, 8'h5B);
    tick();
    vectors++;
    if (ack !== 1'b1) begin
      $display("FAIL clear_vote_ack: ack=%b, want 1", ack);
      miscompares++;
    end
    {c_v, b_v, a_v} = 3'b000;
    clr_f = 1'b1;
    tick();
    clr_f = 1'b0;
    model_reset();
    e_q = 8'h5A; e_mis = 3'b100; e_unc = 1'b0;
    vectors++;
    if (fail_o !== 3'b000 || q_v !== 1'b1 || q !== e_q || mis !== e_mis || unc !== e_unc) begin
      $display("FAIL clear_vote_result: fail=%b qv=%b q=%h mis=%b unc=%b, want fail=000 qv=1 q=5a mis=100 unc=0",
               fail_o, q_v, q, mis, unc);
      miscompares++;
    end
    release_out("clear_vote", 0);
    for (int k = 0; k < 3; k++) begin
      start_set(3'b111, 8'h5A, 8'h5A, 8'h5B);
      await_vote($sformatf("post_clear%0d", k));
      release_out("post_clear", 0);
    end
  endtask

  task automatic test_reset_mid();
    start_set(3'b001, 8'hC3, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (ack !== 1'b0) begin
        $display("FAIL collect_noack%0d: ack=%b, want 0", k, ack);
        miscompares++;
      end
    end
    rn = 1'b0;
    tick();
    vectors++;
    if (q !== 8'h00 || q_v !== 1'b0 || mis !== 3'b000 || unc !== 1'b0 || ack !== 1'b0 || fail_o !== 3'b000) begin
      $display("FAIL reset_mid: q=%h qv=%b mis=%b unc=%b ack=%b fail=%b, want all zero",
               q, q_v, mis, unc, ack, fail_o);
      miscompares++;
    end
    {c_v, b_v, a_v} = 3'b000;
    rn = 1'b1;
    model_reset();
    tick();
  endtask

  function automatic logic [7:0] pick_data();
    case ($urandom_range(0, 4))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h5A;
      3:       return 8'hA5;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] v;
    for (int n = 0; n < 40; n++) begin
      if (m_fail == 3'b111 || $urandom_range(0, 7) == 0) pulse_clear();
      v = 3'($urandom_range(0, 7));
      if ((v & ~m_fail) == 3'b000) v = v | ~m_fail;
      start_set(v, pick_data(), pick_data(), pick_data());
      await_vote($sformatf("rand%0d", n));
      release_out("rand", $urandom_range(0, 3));
    end
  endtask

  initial begin
    rn = 1'b0; q_r = 1'b0; clr_f = 1'b0;
    start_set(3'b000, 8'h00, 8'h00, 8'h00);
    model_reset();
    test_reset();
    test_clean_vote();
    test_upset_and_retire();
    test_degraded();
    test_timeout();
    test_backpressure();
    test_clear_at_vote();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tmr_vote_ctrl.md
# tmr_vote_ctrl

- Sequencing controller for a triple-modular-redundant (TMR) channel set, built around the corelib majority/inverted-majority voting cells.
- Collects one data word from each of three redundant channels, with a timeout if a channel is late.
- Produces a bitwise 2-of-3 vote and flags which channels disagreed with it.
- Keeps per-channel saturating error counts and retires a channel once its count reaches a threshold; a retired channel is no longer waited for or used in voting.

## Interface

Parameters:
- W, 8, data width of each channel and of the voted result.
- TMO, 15, collection timeout in cycles after the first capture (range 1..255).
- ERR_TH, 3, error-count threshold at which a channel is retired (range 1..2^CW-1).
- CW, 4, error-counter width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RN  in  1  reset, synchronous, active-low.
- A_D / B_D / C_D  in  W each  channel data; held stable by the source until ACK.
- A_V / B_V / C_V  in  1 each  channel valid; held high until ACK.
- ACK  out  1  one-cycle pulse; releases all channels for the current vote.
- Q  out  W  voted result.
- Q_V  out  1  result valid; held until Q_R.
- Q_R  in  1  downstream ready.
- MIS  out  3  per-channel mismatch flags {C,B,A}; valid with Q_V.
- UNC  out  1  uncorrectable flag; valid with Q_V.
- FAIL  out  3  retired-channel flags {C,B,A}; always live.
- CLR_F  in  1  clears all error counters and FAIL.

## Operation

- **Active channels.** An active channel is one with FAIL[i]=0. The valid input of a retired channel is ignored and its data is never used.
- **Capture.** Each active channel is captured into a snapshot register on the first cycle its valid is seen. Later valids from the same channel are ignored until the next IDLE.
- **IDLE**
  - Capture any active valids and clear the timer.
  - Fewer than 2 active channels and any valid present -> VOTE.
  - All active channels captured -> VOTE.
  - At least one captured, but not all -> COLLECT.
- **COLLECT**
  - Capture arriving active valids; the timer increments each cycle.
  - All active channels captured -> VOTE.
  - Timer == TMO-1 (i.e. TMO cycles spent in COLLECT) -> VOTE with whatever has been captured.
- **VOTE** (one cycle): register Q, MIS, UNC and the counter/FAIL updates, pulse ACK, go to OUT.
  - Three present: Q = bitwise majority. MIS[i] = (snapshot_i != Q). UNC=0.
  - Two present, equal: Q = that value. MIS[i]=1 only for the absent active channel. UNC=0.
  - Two present, differing: Q = lowest-indexed present channel (A>B>C). MIS=1 for both present and for any absent active channel. UNC=1.
  - Fewer than two present: Q = the present value, or 0 if none. MIS=1 for absent active channels. UNC=1.
  - MIS[i] is always 0 for a retired channel.
- **Error counters.** For each active channel with MIS[i]=1, counter_i increments and saturates at 2^CW-1. FAIL[i] is set in the same update if the new count >= ERR_TH. FAIL is sticky until CLR_F or reset.
- **OUT**
  - Hold Q, MIS, UNC with Q_V=1.
  - On Q_V&&Q_R: clear Q_V, clear snapshot flags, go to IDLE.
  - Channel valids during OUT are ignored (not captured).
- **CLR_F** is honoured in any state, takes effect on the next edge, and wins over a simultaneous counter increment or FAIL set. It does not alter Q, MIS or UNC.

## Timing

- **Reset** (RN=0 at an edge): state IDLE. Q=0, Q_V=0, MIS=0, UNC=0, ACK=0, FAIL=0, all counters=0, timer=0, snapshot flags cleared.
- **Reset mid-operation** aborts the vote with no ACK. Sources must treat reset as a release.
- **All active valids at edge k** (in IDLE): VOTE during cycle k+1, with ACK=1 in that cycle. Q_V=1 from cycle k+2.
- **Staggered valids:** VOTE occurs the cycle after the last active capture.
- **Timeout:** with the first capture at edge k and the set incomplete, VOTE is in cycle k+TMO+1.
- **Handshake:** Q_R high in the first Q_V cycle -> IDLE next cycle. A new set can be captured in that IDLE cycle, giving 3-cycle throughput.
- **Q_R** is ignored while Q_V=0.
- **ACK** is exactly one cycle per vote. It is never asserted in IDLE, COLLECT or OUT.

## Test plan

- **Clean vote:** A=B=C=0x5A, all valid in one cycle.
  - ACK one cycle later, Q=0x5A and Q_V two cycles later.
  - MIS=000, UNC=0; counters stay 0.
- **Single-bit upset:** A=0x5A, B=0x5A, C=0x5B.
  - Q=0x5A, MIS=100, counter_C=1.
  - Repeating the same inputs twice more (ERR_TH=3) sets FAIL=100 on the third vote.
  - Next vote with A=B=0x11 and C invalid: vote without waiting, Q=0x11, MIS=000.
- **Timeout:** A and B valid at edge 0 with 0x33, C never valid, TMO=15.
  - VOTE in cycle 16, Q=0x33, MIS=100, UNC=0.
- **Degraded disagreement:** with FAIL=100, A=0x0F and B=0xF0.
  - Q=0x0F, UNC=1, MIS=011, counters A and B each +1.
- **Backpressure:** hold Q_R=0 for 10 cycles after Q_V.
  - Q, MIS, UNC are stable and there is no further ACK, even while new valids are present.
  - Q_R=1 -> IDLE, and the pending valids are captured.
- **Clear and reset:** assert CLR_F in the same cycle as a VOTE that would set FAIL.
  - FAIL=000 and counters=0 afterwards.
  - Assert RN=0 during COLLECT: all outputs are 0 on the next edge and no ACK is issued.
